riscv_mdu_ctrl: RTL

RISCV_MDU_CTRL -- requirements
Module: riscv_mdu_ctrl

---
 rtl/riscv_config_pkg.sv | 4 +
 rtl/riscv_types_pkg.sv | 20 ++
 rtl/riscv_div_iter.sv | 51 +++++
 rtl/riscv_mdu_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_config_pkg.sv
// Build-wide configuration for the RISC-V integer core slices.
package riscv_config_pkg;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/riscv_types_pkg.sv
// Shared types for the multiply/divide unit: RV32M funct3 opcodes and controller states.
package riscv_types_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;
endpackage

// File: rtl/riscv_div_iter.sv
// Restoring divider datapath on unsigned magnitudes; one quotient bit per enabled cycle.
// The *_nxt outputs expose the result of the step being taken this cycle.
module riscv_div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN:0]   shifted, trial;

  // trial[XLEN] is the borrow: set when the shifted remainder is below the divisor
  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    trial     = shifted - {1'b0, dvs_q};
    quo_nxt_o = {quo_q[XLEN-2:0], ~trial[XLEN]};
    rem_nxt_o = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (en_i) begin
      quo_d = quo_nxt_o;
      rem_d = rem_nxt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end
endmodule

// File: rtl/riscv_mdu_ctrl.sv
// RV32M multiply/divide controller: single-cycle multiply, 32-step iterative divide.
// Optional RISCV_MDU_DIV_REM_FUSE_EN caches the last divide so the paired DIV/REM returns in one cycle.
module riscv_mdu_ctrl
  import riscv_types_pkg::*;
#(
  parameter int unsigned XLEN = riscv_config_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [4:0]      req_rd_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  output logic [4:0]      resp_rd_o,
  output logic            busy_o
);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, data_q, data_d;
  logic [4:0]      rd_q, rd_d, cnt_q, cnt_d;

  logic            accept, in_div, in_sgn, in_rem, div_zero, ovf, fast, div_last, op_sgn;
  logic            fuse_hit, mul_a_sgn, mul_b_sgn;
  logic [XLEN-1:0] fast_res, fuse_res, dvd_mag, dvs_mag, quo_nxt, rem_nxt, quo_fix, rem_fix;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;

  // Incoming request decode and the one-cycle special cases
  always_comb begin
    in_div   = req_funct3_i[2];
    in_sgn   = ~req_funct3_i[0];
    in_rem   = req_funct3_i[1];
    accept   = req_valid_i & req_ready_o & ~flush_i;
    div_zero = (req_rs2_i == '0);
    ovf      = in_sgn & (req_rs1_i == INT_MIN) & (req_rs2_i == '1);
    fast     = in_div & (div_zero | ovf | fuse_hit);
    if (div_zero)      fast_res = in_rem ? req_rs1_i : '1;
    else if (ovf)      fast_res = in_rem ? '0 : INT_MIN;
    else               fast_res = fuse_res;
    dvd_mag  = (in_sgn & req_rs1_i[XLEN-1]) ? -req_rs1_i : req_rs1_i;
    dvs_mag  = (in_sgn & req_rs2_i[XLEN-1]) ? -req_rs2_i : req_rs2_i;
  end

  riscv_div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept & in_div),
    .en_i       (state_q == ST_DIV),
    .dividend_i (dvd_mag),
    .divisor_i  (dvs_mag),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  // Sign fixup: quotient negative when signs differ, remainder follows the dividend
  always_comb begin
    div_last = (state_q == ST_DIV) && (cnt_q == 5'd31);
    op_sgn   = ~op_q[0];
    quo_fix  = (op_sgn & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1])) ? -quo_nxt : quo_nxt;
    rem_fix  = (op_sgn & rs1_q[XLEN-1]) ? -rem_nxt : rem_nxt;
  end

  // Sign-extending to 2*XLEN makes one unsigned multiply cover all four variants
  always_comb begin
    mul_a_sgn = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) & rs1_q[XLEN-1];
    mul_b_sgn = (op_q == OP_MULH) & rs2_q[XLEN-1];
    mul_a     = {{XLEN{mul_a_sgn}}, rs1_q};
    mul_b     = {{XLEN{mul_b_sgn}}, rs2_q};
    prod      = mul_a * mul_b;
  end

`ifdef RISCV_MDU_DIV_REM_FUSE_EN
  logic            fz_vld_q, fz_vld_d, fz_sgn_q, fz_sgn_d, fz_rem_op_q, fz_rem_op_d;
  logic [XLEN-1:0] fz_rs1_q, fz_rs1_d, fz_rs2_q, fz_rs2_d, fz_quo_q, fz_quo_d, fz_rem_q, fz_rem_d;

  // Hit only for the complementary op on identical operands and signedness
  always_comb begin
    fuse_hit = fz_vld_q & in_div & (fz_rs1_q == req_rs1_i) & (fz_rs2_q == req_rs2_i)
             & (fz_sgn_q == in_sgn) & (fz_rem_op_q != in_rem);
    fuse_res = in_rem ? fz_rem_q : fz_quo_q;
    fz_vld_d    = fz_vld_q;
    fz_sgn_d    = fz_sgn_q;
    fz_rem_op_d = fz_rem_op_q;
    fz_rs1_d    = fz_rs1_q;
    fz_rs2_d    = fz_rs2_q;
    fz_quo_d    = fz_quo_q;
    fz_rem_d    = fz_rem_q;
    if (flush_i || (accept && !in_div)) begin
      fz_vld_d = 1'b0;
    end else if (div_last) begin
      fz_vld_d    = 1'b1;
      fz_sgn_d    = op_sgn;
      fz_rem_op_d = op_q[1];
      fz_rs1_d    = rs1_q;
      fz_rs2_d    = rs2_q;
      fz_quo_d    = quo_fix;
      fz_rem_d    = rem_fix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fz_vld_q    <= 1'b0;
      fz_sgn_q    <= 1'b0;
      fz_rem_op_q <= 1'b0;
      fz_rs1_q    <= '0;
      fz_rs2_q    <= '0;
      fz_quo_q    <= '0;
      fz_rem_q    <= '0;
    end else begin
      fz_vld_q    <= fz_vld_d;
      fz_sgn_q    <= fz_sgn_d;
      fz_rem_op_q <= fz_rem_op_d;
      fz_rs1_q    <= fz_rs1_d;
      fz_rs2_q    <= fz_rs2_d;
      fz_quo_q    <= fz_quo_d;
      fz_rem_q    <= fz_rem_d;
    end
  end
`else
  assign fuse_hit = 1'b0;
  assign fuse_res = '0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) state_d = !in_div ? ST_MUL : (fast ? ST_DONE : ST_DIV);
        ST_MUL:  state_d = ST_DONE;
        ST_DIV:  if (cnt_q == 5'd31) state_d = ST_DONE;
        ST_DONE: if (resp_ready_i) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    req_ready_o  = (state_q == ST_IDLE) & ~rst_i;
    busy_o       = (state_q != ST_IDLE) & ~rst_i;
    resp_valid_o = (state_q == ST_DONE) & ~rst_i & ~flush_i;
    resp_data_o  = data_q;
    resp_rd_o    = rd_q;
  end

  always_comb begin
    op_d   = op_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (accept) begin
      op_d  = mdu_op_e'(req_funct3_i);
      rs1_d = req_rs1_i;
      rs2_d = req_rs2_i;
      rd_d  = req_rd_i;
      cnt_d = '0;
      if (fast) data_d = fast_res;
    end
    if (state_q == ST_MUL) data_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (state_q == ST_DIV) begin
      cnt_d = cnt_q + 5'd1;
      if (div_last) data_d = op_q[1] ? rem_fix : quo_fix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q   <= OP_MUL;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      op_q   <= op_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
